packet_scheduler: RTL

PACKET_SCHEDULER -- requirements
Module: packet_scheduler

---
 rtl/packet_scheduler_pkg.sv | 24 ++
 rtl/packet_scheduler_if.sv | 23 ++
 rtl/packet_scheduler_interval_timer.sv | 25 ++
 rtl/packet_scheduler.sv | 104 ++++++++++
 4 files changed

// File: rtl/packet_scheduler_pkg.sv
// Shared packet type codes and the pending-flag record for the packet scheduler.
// Optional macro SPD_EN adds the SPD InfoFrame flag to the record.
package packet_scheduler_pkg;

    localparam logic [7:0] PKT_NULL         = 8'h00;
    localparam logic [7:0] PKT_ACR          = 8'h01;
    localparam logic [7:0] PKT_AUDIO_SAMPLE = 8'h02;
    localparam logic [7:0] PKT_AVI_IF       = 8'h82;
    localparam logic [7:0] PKT_SPD_IF       = 8'h83;
    localparam logic [7:0] PKT_AUDIO_IF     = 8'h84;

    typedef struct packed {
        logic acr;
        logic avi;
        logic audio_if;
`ifdef SPD_EN
        logic spd;
`endif
    } pending_t;

    // Every flagged packet is owed straight out of reset.
    localparam pending_t PENDING_RESET = '1;

endpackage

// File: rtl/packet_scheduler_if.sv
// Scheduler <-> HDMI core bundle: frame timing, packet handshake, audio buffer pop.
// The scheduler uses the master modport, the HDMI core side the slave modport.
interface packet_scheduler_if #(
    parameter int REMAINING_WIDTH = 8
);
    logic                       frame_start;
    logic                       packet_enable;
    logic [REMAINING_WIDTH-1:0] audio_remaining;
    logic [7:0]                 packet_type;
    logic                       audio_pop;
    logic [2:0]                 audio_pop_count;
    logic                       acr_overrun;

    modport master (
        input  frame_start, packet_enable, audio_remaining,
        output packet_type, audio_pop, audio_pop_count, acr_overrun
    );

    modport slave (
        output frame_start, packet_enable, audio_remaining,
        input  packet_type, audio_pop, audio_pop_count, acr_overrun
    );
endinterface

// File: rtl/packet_scheduler_interval_timer.sv
// Free-running 0..PERIOD-1 counter; wrap is high during the last count of each interval.
module interval_timer #(
    parameter int PERIOD = 27000
)(
    input  logic clk_pixel,
    input  logic reset,
    output logic wrap
);
    localparam int              CW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0]   LAST = CW'(PERIOD - 1);

    logic [CW-1:0] count;

    assign wrap = (count == LAST);

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (wrap) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end
endmodule

// File: rtl/packet_scheduler.sv
// HDMI data-island packet scheduler: ACR > AVI > Audio InfoFrame (> SPD) > audio samples > null.
// Optional macro SPD_EN adds the SPD InfoFrame (8'h83) between Audio InfoFrame and samples.
module packet_scheduler
    import packet_scheduler_pkg::*;
#(
    parameter int SAMPLES_PER_PACKET = 4,
    parameter int ACR_PERIOD         = 27000,
    parameter int INFOFRAME_FRAMES   = 1,
    parameter int REMAINING_WIDTH    = 8
)(
    input  logic               clk_pixel,
    input  logic               reset,
    packet_scheduler_if.master pkt
);
    localparam logic [7:0] FRAME_LAST = 8'(INFOFRAME_FRAMES - 1);
    localparam logic [2:0] POP_COUNT  = 3'(SAMPLES_PER_PACKET);

    pending_t                   pend_q;
    pending_t                   pend_d;
    logic [7:0]                 frame_cnt_q;
    logic                       overrun_q;
    logic                       acr_wrap;
    logic                       audio_ready;
    logic                       consume_acr;
    logic                       frame_arm;
    logic                       pop;
    logic [7:0]                 sel_type;
    logic [REMAINING_WIDTH-1:0] remaining;

    interval_timer #(
        .PERIOD (ACR_PERIOD)
    ) u_acr_timer (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .wrap      (acr_wrap)
    );

    assign remaining   = pkt.audio_remaining;
    // Only whole packets are sent; a short buffer waits for more samples.
    assign audio_ready = (32'(remaining) >= $unsigned(SAMPLES_PER_PACKET));
    assign consume_acr = pkt.packet_enable && pend_q.acr;
    assign frame_arm   = pkt.frame_start && (frame_cnt_q == 8'd0);
    assign pop         = pkt.packet_enable && (sel_type == PKT_AUDIO_SAMPLE);

    always_comb begin
        sel_type = PKT_NULL;
        if (pend_q.acr)           sel_type = PKT_ACR;
        else if (pend_q.avi)      sel_type = PKT_AVI_IF;
        else if (pend_q.audio_if) sel_type = PKT_AUDIO_IF;
`ifdef SPD_EN
        else if (pend_q.spd)      sel_type = PKT_SPD_IF;
`endif
        else if (audio_ready)     sel_type = PKT_AUDIO_SAMPLE;
    end

    // Consumption clears first so a coincident set takes precedence.
    always_comb begin
        pend_d = pend_q;
        if (pkt.packet_enable) begin
            case (sel_type)
                PKT_ACR:      pend_d.acr      = 1'b0;
                PKT_AVI_IF:   pend_d.avi      = 1'b0;
                PKT_AUDIO_IF: pend_d.audio_if = 1'b0;
`ifdef SPD_EN
                PKT_SPD_IF:   pend_d.spd      = 1'b0;
`endif
                default:      ;
            endcase
        end
        if (acr_wrap) begin
            pend_d.acr = 1'b1;
        end
        if (frame_arm) begin
            pend_d.avi      = 1'b1;
            pend_d.audio_if = 1'b1;
`ifdef SPD_EN
            pend_d.spd      = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            pend_q      <= PENDING_RESET;
            overrun_q   <= 1'b0;
            frame_cnt_q <= 8'd0;
        end else begin
            pend_q <= pend_d;
            // A wrap landing on a still-unsent ACR means one request is lost.
            if (acr_wrap && pend_q.acr && !consume_acr) begin
                overrun_q <= 1'b1;
            end
            if (pkt.frame_start) begin
                frame_cnt_q <= (frame_cnt_q == FRAME_LAST) ? 8'd0 : frame_cnt_q + 8'd1;
            end
        end
    end

    assign pkt.packet_type     = sel_type;
    assign pkt.audio_pop       = pop;
    assign pkt.audio_pop_count = pop ? POP_COUNT : 3'd0;
    assign pkt.acr_overrun     = overrun_q;

endmodule
